// File: rtl/req_enc_pkg.sv
// req_enc_pkg: shared widths and FSM state encoding for req_encoder8
package req_enc_pkg;
    localparam int N  = 8;
    localparam int IW = 3;
    typedef enum logic {IDLE, PRESENT} state_t;
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: finds the first set bit of vec searching upward from start, wrapping 7 -> 0
module prio_enc8
    import req_enc_pkg::*;
(
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Walk offsets downward so the smallest offset from start wins
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[start + IW'(i)]) begin
                idx   = start + IW'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/req_encoder8.sv
// req_encoder8: sticky 8-line request collector emitting one 3-bit index per valid/ready transfer
// Define ROUND_ROBIN_EN for rotating selection; otherwise lowest index wins.
module req_encoder8
    import req_enc_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic [N-1:0]  req_in,
    input  logic          clr_all,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic [N-1:0]  out_onehot,
    output logic [N-1:0]  pending,
    output logic          merged
);
    state_t        state, state_nx;
    logic [IW-1:0] start, sel;
    logic          found, load;
    logic [N-1:0]  grant, pend_nx;

    prio_enc8 u_prio (
        .vec   (pending),
        .start (start),
        .idx   (sel),
        .found (found)
    );

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;
    assign start = rr_ptr;
    // Pointer survives clr_all so fairness is kept across flushes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (load && !clr_all)
            rr_ptr <= sel + IW'(1);
    end
`else
    assign start = '0;
`endif

    always_comb begin
        load     = found && (state == IDLE || out_ready);
        grant    = load ? N'(1) << sel : '0;
        pend_nx  = clr_all ? req_in : (pending & ~grant) | req_in;
        state_nx = clr_all ? IDLE :
                   load ? PRESENT :
                   (state == PRESENT && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pending    <= '0;
            merged     <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
        end else begin
            state   <= state_nx;
            pending <= pend_nx;
            merged  <= |(req_in & pending);
            if (clr_all || state_nx == IDLE)
                out_onehot <= '0;
            else if (load) begin
                out_idx    <= sel;
                out_onehot <= grant;
            end
        end
    end

    assign out_valid = (state == PRESENT);
endmodule

// File: tb/tb_req_encoder8.sv
// tb_req_encoder8: directed self-checking bench for req_encoder8
module tb_req_encoder8;
    import req_enc_pkg::*;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req_in = '0;
    logic          clr_all = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic [N-1:0]  out_onehot;
    logic [N-1:0]  pending;
    logic          merged;
    logic [17:0]   obs;
    int            passed = 0;
    int            total = 0;

    req_encoder8 dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_in     (req_in),
        .clr_all    (clr_all),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .pending    (pending),
        .merged     (merged)
    );

    assign obs = {out_valid, out_onehot, pending, merged};

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({out_idx, obs} !== 21'h0) $display("FAIL reset_state: got %h expected 0", {out_idx, obs});
        else passed++;
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (obs !== 18'h0) $display("FAIL idle_quiet[%0d]: got %h expected 0", k, obs);
            else passed++;
        end
    endtask

    task automatic test_pair;
        out_ready = 1'b1;
        req_in = 8'h24;
        tick();
        req_in = '0;
        total++;
        if (obs !== {1'b0, 8'h00, 8'h24, 1'b0}) $display("FAIL pair_latch: got %h expected %h", obs, {1'b0, 8'h00, 8'h24, 1'b0});
        else passed++;
        tick();
        total++;
        if ({out_idx, obs} !== {3'd2, 1'b1, 8'h04, 8'h20, 1'b0}) $display("FAIL pair_first: got %h expected %h", {out_idx, obs}, {3'd2, 1'b1, 8'h04, 8'h20, 1'b0});
        else passed++;
        tick();
        total++;
        if ({out_idx, obs} !== {3'd5, 1'b1, 8'h20, 8'h00, 1'b0}) $display("FAIL pair_second: got %h expected %h", {out_idx, obs}, {3'd5, 1'b1, 8'h20, 8'h00, 1'b0});
        else passed++;
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL pair_idle: got %h expected 0", obs);
        else passed++;
    endtask

    task automatic test_hold;
        out_ready = 1'b0;
        req_in = 8'h81;
        tick();
        req_in = '0;
        tick();
        total++;
        if ({out_idx, obs} !== {3'd0, 1'b1, 8'h01, 8'h80, 1'b0}) $display("FAIL hold_load: got %h expected %h", {out_idx, obs}, {3'd0, 1'b1, 8'h01, 8'h80, 1'b0});
        else passed++;
        for (int k = 0; k < 5; k++) begin
            req_in = (k == 1) ? 8'h80 : 8'h00;
            tick();
            total++;
            if ({out_idx, obs} !== {3'd0, 1'b1, 8'h01, 8'h80, k == 1}) $display("FAIL hold_stall[%0d]: got %h expected %h", k, {out_idx, obs}, {3'd0, 1'b1, 8'h01, 8'h80, k == 1});
            else passed++;
        end
        req_in = '0;
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_idx, obs} !== {3'd7, 1'b1, 8'h80, 8'h00, 1'b0}) $display("FAIL hold_next: got %h expected %h", {out_idx, obs}, {3'd7, 1'b1, 8'h80, 8'h00, 1'b0});
        else passed++;
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL hold_idle: got %h expected 0", obs);
        else passed++;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        req_in = 8'h08;
        tick();
        req_in = '0;
        tick();
        req_in = 8'h08;
        tick();
        req_in = '0;
        total++;
        if ({out_idx, obs} !== {3'd3, 1'b1, 8'h08, 8'h08, 1'b0}) $display("FAIL rereq_stall: got %h expected %h", {out_idx, obs}, {3'd3, 1'b1, 8'h08, 8'h08, 1'b0});
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_idx, obs} !== {3'd3, 1'b1, 8'h08, 8'h00, 1'b0}) $display("FAIL rereq_again: got %h expected %h", {out_idx, obs}, {3'd3, 1'b1, 8'h08, 8'h00, 1'b0});
        else passed++;
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL rereq_idle: got %h expected 0", obs);
        else passed++;
    endtask

    task automatic test_clr_all;
        out_ready = 1'b0;
        req_in = 8'hF1;
        tick();
        req_in = '0;
        tick();
        total++;
        if (obs !== {1'b1, 8'h01, 8'hF0, 1'b0}) $display("FAIL clr_setup: got %h expected %h", obs, {1'b1, 8'h01, 8'hF0, 1'b0});
        else passed++;
        clr_all = 1'b1;
        req_in = 8'h02;
        tick();
        clr_all = 1'b0;
        req_in = '0;
        total++;
        if (obs !== {1'b0, 8'h00, 8'h02, 1'b0}) $display("FAIL clr_flush: got %h expected %h", obs, {1'b0, 8'h00, 8'h02, 1'b0});
        else passed++;
        tick();
        total++;
        if ({out_idx, obs} !== {3'd1, 1'b1, 8'h02, 8'h00, 1'b0}) $display("FAIL clr_after: got %h expected %h", {out_idx, obs}, {3'd1, 1'b1, 8'h02, 8'h00, 1'b0});
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL clr_idle: got %h expected 0", obs);
        else passed++;
    endtask

    task automatic test_round_robin;
        logic [IW-1:0] ei;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        req_in = 8'hFF;
        tick();
        total++;
        if (obs !== {1'b0, 8'h00, 8'hFF, 1'b0}) $display("FAIL rr_latch: got %h expected %h", obs, {1'b0, 8'h00, 8'hFF, 1'b0});
        else passed++;
        for (int k = 0; k < 16; k++) begin
`ifdef ROUND_ROBIN_EN
            ei = IW'(k % 8);
`else
            ei = '0;
`endif
            tick();
            total++;
            if ({out_idx, obs} !== {ei, 1'b1, 8'h01 << ei, 8'hFF, 1'b1}) $display("FAIL rr_seq[%0d]: got %h expected %h", k, {out_idx, obs}, {ei, 1'b1, 8'h01 << ei, 8'hFF, 1'b1});
            else passed++;
        end
        req_in = '0;
    endtask

    task automatic test_drain;
        logic [N-1:0] eo, ep;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        out_ready = 1'b0;
        req_in = 8'hFF;
        tick();
        req_in = '0;
        tick();
        total++;
        if ({out_idx, obs} !== {3'd0, 1'b1, 8'h01, 8'hFE, 1'b0}) $display("FAIL drain_first: got %h expected %h", {out_idx, obs}, {3'd0, 1'b1, 8'h01, 8'hFE, 1'b0});
        else passed++;
        out_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            eo = 8'h01 << k;
            ep = 8'hFF << (k + 1);
            tick();
            total++;
            if ({out_idx, obs} !== {IW'(k), 1'b1, eo, ep, 1'b0}) $display("FAIL drain[%0d]: got %h expected %h", k, {out_idx, obs}, {IW'(k), 1'b1, eo, ep, 1'b0});
            else passed++;
        end
        tick();
        total++;
        if (obs !== 18'h0) $display("FAIL drain_idle: got %h expected 0", obs);
        else passed++;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        req_in = 8'h04;
        tick();
        req_in = '0;
        tick();
        total++;
        if ({out_idx, obs} !== {3'd2, 1'b1, 8'h04, 8'h00, 1'b0}) $display("FAIL areset_setup: got %h expected %h", {out_idx, obs}, {3'd2, 1'b1, 8'h04, 8'h00, 1'b0});
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({out_idx, obs} !== 21'h0) $display("FAIL areset_clear: got %h expected 0", {out_idx, obs});
        else passed++;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pair();
        test_hold();
        test_back_to_back();
        test_clr_all();
        test_round_robin();
        test_drain();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
